// File: rtl/mem_access_arbiter.sv
// Fixed-priority sequencer for the shared memory address port (exc > data > fetch).
// Holds IorD/MemWR/grant for LAT cycles, then gives the winner a one-cycle done pulse.
module mem_access_arbiter #(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_fetch,
    input  logic       req_data,
    input  logic       data_we,
    input  logic       req_exc,
    input  logic       exc_sel,
    output logic [1:0] IorD,
    output logic       MemWR,
    output logic       busy,
    output logic [2:0] grant,
    output logic       done_fetch,
    output logic       done_data,
    output logic       done_exc
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] iord_n;
    logic       we_n;
    logic [2:0] grant_n;
    logic [2:0] done_r, done_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            IorD   <= 2'b00;
            MemWR  <= 1'b0;
            grant  <= 3'b000;
            done_r <= 3'b000;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            IorD   <= iord_n;
            MemWR  <= we_n;
            grant  <= grant_n;
            done_r <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        iord_n  = IorD;
        we_n    = MemWR;
        grant_n = grant;
        done_n  = 3'b000;
        case (state)
            IDLE: begin
                iord_n  = 2'b00;
                we_n    = 1'b0;
                grant_n = 3'b000;
                if (req_exc) begin
                    iord_n  = {1'b1, exc_sel};
                    grant_n = 3'b100;
                end else if (req_data) begin
                    iord_n  = 2'b01;
                    we_n    = data_we;
                    grant_n = 3'b010;
                end else if (req_fetch) begin
                    grant_n = 3'b001;
                end
                if (req_exc || req_data || req_fetch) begin
                    cnt_n   = CNT_LOAD;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                // Address and grant stay put; only the latency counter moves.
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    we_n    = 1'b0;
                    done_n  = grant;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                // IorD/grant were held through this cycle so read data can be captured.
                state_n = IDLE;
                iord_n  = 2'b00;
                grant_n = 3'b000;
                cnt_n   = 4'd0;
            end
            default: begin
                state_n = IDLE;
                iord_n  = 2'b00;
                we_n    = 1'b0;
                grant_n = 3'b000;
                cnt_n   = 4'd0;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign {done_exc, done_data, done_fetch} = done_r;

endmodule
